// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer
//   Takes a 48-bit SD command packet from the packet former and shifts it out
//   MSB-first on the CMD line. It generates sdClk itself, optionally captures
//   the card's 48-bit response within an NCR window, and then holds the line
//   idle for the NCC gap before it accepts the next command.
//
//   Ports
//     clk, reset    system clock, asynchronous active-high reset
//     cmdPkt        command packet {start, dir, index, arg, crc7, end}
//     newCmdStrb    one-clk strobe, cmdPkt valid (ignored while busy)
//     respExpected  sampled with newCmdStrb, 1 = a 48-bit response follows
//     cmdIn         CMD line from the card
//     sdClk         SD card clock, free-running
//     cmdOut/cmdOe  CMD line drive value and output enable
//     busy          transaction in progress
//     cmdDoneStrb   one-clk pulse, last command bit sent
//     respPkt       captured response, start bit in bit 47
//     respStrb      one-clk pulse, respPkt updated
//     respTimeout   one-clk pulse, no start bit within RESP_TIMEOUT
//
//   Build option
//     SD_CMD_CRC7_GEN_EN  When defined, the block generates the CRC7 over
//                         bits 47:8 and sends it in place of cmdPkt[7:1].
//                         It also forces the end bit to 1.

module sd_cmd_serializer #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 64,
    parameter int NCC_CYCLES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] cmdPkt,
    input  logic        newCmdStrb,
    input  logic        respExpected,
    input  logic        cmdIn,
    output logic        sdClk,
    output logic        cmdOut,
    output logic        cmdOe,
    output logic        busy,
    output logic        cmdDoneStrb,
    output logic [47:0] respPkt,
    output logic        respStrb,
    output logic        respTimeout
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam int NW = $clog2(NCC_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RESP_TIMEOUT - 1);
    localparam logic [NW-1:0] NCC_LAST = NW'(NCC_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_NCC} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          sdclk_q, sdclk_d;
    logic [47:0]   sh_q, sh_d;          // tx shifter, reused as the rx shifter
    logic          resp_exp_q, resp_exp_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [NW-1:0] ncc_cnt_q, ncc_cnt_d;
    logic          cmd_out_q, cmd_out_d;
    logic          cmd_oe_q, cmd_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          resp_strb_q, resp_strb_d;
    logic          resp_to_q, resp_to_d;
    logic [47:0]   resp_pkt_q, resp_pkt_d;
`ifdef SD_CMD_CRC7_GEN_EN
    logic [6:0]    crc_q, crc_d;
`endif

    logic wrap, fall_ev, rise_ev, tx_bit;

    // The events are decoded one clk ahead. The flops they steer update on
    // the same edge that sdClk toggles.
    always_comb begin
        wrap    = (div_q == DIV_LAST);
        fall_ev = wrap & sdclk_q;
        rise_ev = wrap & ~sdclk_q;
    end

    // bit_cnt_q = number of bits already driven. The next bit is 47-bit_cnt_q.
    always_comb begin
        tx_bit = sh_q[47];
`ifdef SD_CMD_CRC7_GEN_EN
        if (bit_cnt_q == 6'd47)
            tx_bit = 1'b1;
        else if (bit_cnt_q >= 6'd40)
            tx_bit = crc_q[6];
`endif
    end

    always_comb begin
        div_d       = wrap ? '0 : div_q + 1'b1;
        sdclk_d     = wrap ? ~sdclk_q : sdclk_q;
        state_d     = state_q;
        sh_d        = sh_q;
        resp_exp_d  = resp_exp_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        ncc_cnt_d   = ncc_cnt_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        resp_strb_d = 1'b0;
        resp_to_d   = 1'b0;
        resp_pkt_d  = resp_pkt_q;
`ifdef SD_CMD_CRC7_GEN_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (newCmdStrb) begin
                    sh_d       = cmdPkt;
                    resp_exp_d = respExpected;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    to_cnt_d   = '0;
                    ncc_cnt_d  = '0;
`ifdef SD_CMD_CRC7_GEN_EN
                    crc_d      = '0;
`endif
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (fall_ev) begin
                    if (bit_cnt_q == 6'd48) begin
                        // Bit 0 has been held a full period, so release the line.
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = resp_exp_q ? S_WAIT : S_NCC;
                    end else begin
                        cmd_oe_d  = 1'b1;
                        cmd_out_d = tx_bit;
                        sh_d      = {sh_q[46:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef SD_CMD_CRC7_GEN_EN
                        if (bit_cnt_q < 6'd40)
                            crc_d = {crc_q[5:0], 1'b0} ^ ({7{sh_q[47] ^ crc_q[6]}} & 7'h09);
                        else if (bit_cnt_q < 6'd47)
                            crc_d = {crc_q[5:0], 1'b0};
`endif
                    end
                end
            end
            S_WAIT: begin
                if (rise_ev) begin
                    if (!cmdIn) begin
                        sh_d      = '0;     // start bit (0) occupies the LSB
                        bit_cnt_d = 6'd1;
                        state_d   = S_RECV;
                    end else if (to_cnt_q == TO_LAST) begin
                        resp_to_d = 1'b1;
                        state_d   = S_NCC;
                    end else begin
                        to_cnt_d  = to_cnt_q + 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (rise_ev) begin
                    sh_d = {sh_q[46:0], cmdIn};
                    if (bit_cnt_q == 6'd47) begin
                        resp_pkt_d  = {sh_q[46:0], cmdIn};
                        resp_strb_d = 1'b1;
                        state_d     = S_NCC;
                    end else begin
                        bit_cnt_d   = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_NCC: begin
                if (rise_ev) begin
                    if (ncc_cnt_q == NCC_LAST) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ncc_cnt_d = ncc_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sdclk_q     <= 1'b0;
            sh_q        <= '0;
            resp_exp_q  <= 1'b0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ncc_cnt_q   <= '0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_strb_q <= 1'b0;
            resp_to_q   <= 1'b0;
            resp_pkt_q  <= '0;
`ifdef SD_CMD_CRC7_GEN_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sdclk_q     <= sdclk_d;
            sh_q        <= sh_d;
            resp_exp_q  <= resp_exp_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ncc_cnt_q   <= ncc_cnt_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resp_strb_q <= resp_strb_d;
            resp_to_q   <= resp_to_d;
            resp_pkt_q  <= resp_pkt_d;
`ifdef SD_CMD_CRC7_GEN_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign sdClk       = sdclk_q;
    assign cmdOut      = cmd_out_q;
    assign cmdOe       = cmd_oe_q;
    assign busy        = busy_q;
    assign cmdDoneStrb = done_q;
    assign respPkt     = resp_pkt_q;
    assign respStrb    = resp_strb_q;
    assign respTimeout = resp_to_q;

endmodule
